axi_slave_ram: RTL

AXI_SLAVE_RAM -- requirements
Module: axi_slave_ram

---
 rtl/axi_slave_ram_pkg.sv | 18 +
 rtl/axi_ram_core.sv | 40 ++++
 rtl/axi_slave_ram.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_ram_pkg.sv
// Shared FSM encodings and AXI response codes for the AXI slave RAM.
package axi_slave_ram_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_ram_core.sv
// Word-addressed RAM: one byte-enabled write port, one registered read port.
module axi_ram_core #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_i,
    input  logic [MEM_AW-1:0]   waddr_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                re_i,
    input  logic [MEM_AW-1:0]   raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [2**MEM_AW];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto RAM macros; contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W/8; b++) begin
            if (we_i && wstrb_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // NOTE: non-blocking read of mem_q sees the pre-write word on a same-edge collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 INCR-burst slave backed by a single-port-pair RAM; write and read FSMs run independently.
module axi_slave_ram
    import axi_slave_ram_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int              BSH      = $clog2(DATA_W/8);
    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(DATA_W/8);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> (BSH + MEM_AW)) == '0;
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return MEM_AW'(a >> BSH);
    endfunction

    w_state_e          w_state_q, w_state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic              werr_q, werr_d;
    logic              w_last_beat, ram_we;

    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d, rd_addr;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic              rlast_q, rlast_d, roor_q, roor_d, ram_re;
    logic [DATA_W-1:0] ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rlast_q   <= 1'b0;
            roor_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rlast_q   <= rlast_d;
            roor_q    <= roor_d;
        end
    end

    assign w_last_beat = (wcnt_q == wlen_q);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = OKAY;
        ram_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) begin
                    waddr_d   = awaddr;
                    wlen_d    = awlen;
                    wcnt_d    = '0;
                    werr_d    = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    ram_we  = in_range(waddr_q);
                    if (!in_range(waddr_q) || (wlast != w_last_beat)) werr_d = 1'b1;
                    waddr_d = waddr_q + ADDR_INC;
                    wcnt_d  = wcnt_q + 8'd1;
                    // Burst length is authoritative; a misplaced wlast only flags an error.
                    if (w_last_beat) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = werr_q ? SLVERR : OKAY;
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rlast_d   = rlast_q;
        roor_d    = roor_q;
        rd_addr   = raddr_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        ram_re    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    rd_addr   = araddr;
                    ram_re    = in_range(araddr);
                    roor_d    = !in_range(araddr);
                    raddr_d   = araddr + ADDR_INC;
                    rlen_d    = arlen;
                    rcnt_d    = '0;
                    rlast_d   = (arlen == 8'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        roor_d    = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        ram_re  = in_range(raddr_q);
                        roor_d  = !in_range(raddr_q);
                        raddr_d = raddr_q + ADDR_INC;
                        rcnt_d  = rcnt_q + 8'd1;
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    axi_ram_core #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ram_we),
        .waddr_i (word_idx(waddr_q)),
        .wstrb_i (wstrb),
        .wdata_i (wdata),
        .re_i    (ram_re),
        .raddr_i (word_idx(rd_addr)),
        .rdata_o (ram_rdata)
    );

    // Out-of-range beats read as zero regardless of what the RAM register holds.
    assign rdata = roor_q ? '0 : ram_rdata;
    assign rresp = roor_q ? SLVERR : OKAY;
    assign rlast = rlast_q;

endmodule
